// File: rtl/arb_pkg.sv
// Shared types and constants for the parametrised grant arbiter.
// Imported by arb_pick and arb_fsm_param.
package arb_pkg;

  // Two-bit encoding leaves spare codes; any of them falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01
  } arb_state_t;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection over a candidate mask.
// Supports fixed priority (lowest index wins) and rotating priority starting at ptr.
module arb_pick
  import arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [ID_W-1:0]    ptr,
  input  logic               mode,
  output logic [ID_W-1:0]    win_id,
  output logic               found
);

  logic            lo_found;
  logic            hi_found;
  logic [ID_W-1:0] lo_idx;
  logic [ID_W-1:0] hi_idx;

  // The rotating search is split into two scans: the first set bit at or above
  // ptr, otherwise the lowest set bit overall (the wrapped part).
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (mask[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
      end
      if (mask[i] && !hi_found && (ID_W'(i) >= ptr)) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(i);
      end
    end
  end

  always_comb begin
    found  = lo_found;
    win_id = lo_idx;
    if (mode == ARB_RR && hi_found) begin
      win_id = hi_idx;
    end
  end

endmodule

// File: rtl/arb_fsm_param.sv
// N-agent grant arbiter: fixed or round-robin priority, optional back-to-back
// handover and a maximum-hold timer that preempts a hogging owner.
module arb_fsm_param
  import arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned RR_MODE   = 1,
  parameter  int unsigned BACK2BACK = 1,
  parameter  int unsigned MAX_HOLD  = 16,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               preempt
);

  localparam int unsigned     CNT_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic             PICK_MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] others;
  logic [NUM_REQ-1:0] cand;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic               owner_req;
  logic               timeout;
  logic               new_grant;
  logic               preempt_d;

  assign owner_mask = NUM_REQ'(1) << owner_q;
  assign owner_req  = |(req & owner_mask);
  assign others     = req & ~owner_mask;
  // While granted, the owner is always excluded: on release its bit is already
  // clear, and on timeout it must not win again.
  assign cand       = (state_q == GRANT) ? others : req;
  assign timeout    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .mask   (cand),
    .ptr    (rr_ptr_q),
    .mode   (PICK_MODE),
    .win_id (win_id),
    .found  (win_found)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    rr_ptr_d  = rr_ptr_q;
    preempt_d = 1'b0;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = GRANT;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if ((BACK2BACK != 0) && win_found) begin
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (timeout) begin
          if (win_found) begin
            new_grant = 1'b1;
            preempt_d = 1'b1;
          end
        end else if (MAX_HOLD != 0) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
        hold_d  = '0;
      end
    endcase
    if (new_grant) begin
      owner_d  = win_id;
      hold_d   = '0;
      rr_ptr_d = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      hold_q    <= '0;
      rr_ptr_q  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      preempt   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt       <= (state_d == GRANT) ? (NUM_REQ'(1) << owner_d) : '0;
      gnt_valid <= (state_d == GRANT);
      gnt_id    <= (state_d == GRANT) ? owner_d : '0;
      preempt   <= preempt_d;
    end
  end

endmodule

// File: tb/tb_arb_fsm_param.sv
// Directed bench for arb_fsm_param: three configurations side by side, a vector
// table for fixed/round-robin instances plus hand sequences for the corner cases.
module tb_arb_fsm_param;

  logic       clock;
  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;

  logic [3:0] gnt_f, gnt_r, gnt_n;
  logic       val_f, val_r, val_n;
  logic [1:0] id_f, id_r, id_n;
  logic       pre_f, pre_r, pre_n;

  int n_pass  = 0;
  int n_total = 0;

  arb_fsm_param #(.NUM_REQ(4), .RR_MODE(0), .BACK2BACK(1), .MAX_HOLD(4)) u_fix (
    .clock(clock), .reset(rst_a), .req(req_a),
    .gnt(gnt_f), .gnt_valid(val_f), .gnt_id(id_f), .preempt(pre_f));

  arb_fsm_param #(.NUM_REQ(4), .RR_MODE(1), .BACK2BACK(1), .MAX_HOLD(4)) u_rr (
    .clock(clock), .reset(rst_a), .req(req_a),
    .gnt(gnt_r), .gnt_valid(val_r), .gnt_id(id_r), .preempt(pre_r));

  arb_fsm_param #(.NUM_REQ(4), .RR_MODE(1), .BACK2BACK(0), .MAX_HOLD(0)) u_nb (
    .clock(clock), .reset(rst_b), .req(req_b),
    .gnt(gnt_n), .gnt_valid(val_n), .gnt_id(id_n), .preempt(pre_n));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gf;
    logic       pf;
    logic [3:0] gr;
    logic       pr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_dut(input string tag, input logic [3:0] g, input logic v,
                         input logic [1:0] id, input logic p,
                         input logic [3:0] eg, input logic ep);
    chk({tag, " gnt"}, g, eg);
    chk({tag, " gnt_valid"}, 4'(v), 4'(|eg));
    chk({tag, " gnt_id"}, 4'(id), 4'(idx_of(eg)));
    chk({tag, " preempt"}, 4'(p), 4'(ep));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] gf, input logic pf,
                     input logic [3:0] gr, input logic pr);
    vecs.push_back('{req: r, gf: gf, pf: pf, gr: gr, pr: pr});
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;

    //    req      fix gnt  pre  rr gnt  pre
    add(4'b1010, 4'b0010, 0, 4'b0010, 0);
    add(4'b1010, 4'b0010, 0, 4'b0010, 0);
    add(4'b1000, 4'b1000, 0, 4'b1000, 0);
    add(4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(4'b1111, 4'b0001, 0, 4'b0001, 0);
    add(4'b1110, 4'b0010, 0, 4'b0010, 0);
    add(4'b1111, 4'b0010, 0, 4'b0010, 0);
    add(4'b1111, 4'b0010, 0, 4'b0010, 0);
    add(4'b1111, 4'b0010, 0, 4'b0010, 0);
    add(4'b1111, 4'b0001, 1, 4'b0100, 1);
    add(4'b1111, 4'b0001, 0, 4'b0100, 0);
    add(4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(4'b0001, 4'b0001, 0, 4'b0001, 0);
    for (int i = 0; i < 9; i++) add(4'b0001, 4'b0001, 0, 4'b0001, 0);
    add(4'b0011, 4'b0010, 1, 4'b0010, 1);
    add(4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(4'b0100, 4'b0100, 0, 4'b0100, 0);
    add(4'b1100, 4'b0100, 0, 4'b0100, 0);
    add(4'b1100, 4'b0100, 0, 4'b0100, 0);
    add(4'b1100, 4'b0100, 0, 4'b0100, 0);
    add(4'b1000, 4'b1000, 0, 4'b1000, 0);
    add(4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(4'b1111, 4'b0001, 0, 4'b0001, 0);
    add(4'b1110, 4'b0010, 0, 4'b0010, 0);
    add(4'b1101, 4'b0001, 0, 4'b0100, 0);
    add(4'b1011, 4'b0001, 0, 4'b1000, 0);
    add(4'b0111, 4'b0001, 0, 4'b0001, 0);
    add(4'b0000, 4'b0000, 0, 4'b0000, 0);

    step();
    chk_dut("reset fix", gnt_f, val_f, id_f, pre_f, 4'b0000, 1'b0);
    chk_dut("reset rr",  gnt_r, val_r, id_r, pre_r, 4'b0000, 1'b0);
    chk_dut("reset nb",  gnt_n, val_n, id_n, pre_n, 4'b0000, 1'b0);
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;

    foreach (vecs[i]) begin
      req_a = vecs[i].req;
      step();
      chk_dut($sformatf("row%0d fix", i), gnt_f, val_f, id_f, pre_f, vecs[i].gf, vecs[i].pf);
      chk_dut($sformatf("row%0d rr", i),  gnt_r, val_r, id_r, pre_r, vecs[i].gr, vecs[i].pr);
    end

    // Asynchronous reset mid-grant, then restart with pointer back at 0.
    req_a = 4'b0100;
    step();
    chk("pre-reset rr gnt", gnt_r, 4'b0100);
    #3 rst_a = 1'b0;
    #1;
    chk_dut("async reset fix", gnt_f, val_f, id_f, pre_f, 4'b0000, 1'b0);
    chk_dut("async reset rr",  gnt_r, val_r, id_r, pre_r, 4'b0000, 1'b0);
    req_a = 4'b0110;
    #2 rst_a = 1'b1;
    step();
    chk_dut("post-reset rr", gnt_r, val_r, id_r, pre_r, 4'b0010, 1'b0);
    chk_dut("post-reset fix", gnt_f, val_f, id_f, pre_f, 4'b0010, 1'b0);
    #3 rst_a = 1'b0;
    #1;
    chk("async reset2 rr gnt", gnt_r, 4'b0000);
    req_a = 4'b0101;
    #2 rst_a = 1'b1;
    step();
    chk_dut("ptr cleared rr", gnt_r, val_r, id_r, pre_r, 4'b0001, 1'b0);
    req_a = 4'b0000;

    // No back-to-back: one idle cycle between owners; MAX_HOLD=0 never preempts.
    req_b = 4'b0100;
    step();
    chk_dut("nb first", gnt_n, val_n, id_n, pre_n, 4'b0100, 1'b0);
    req_b = 4'b1100;
    for (int i = 0; i < 20; i++) step();
    chk_dut("nb long hold", gnt_n, val_n, id_n, pre_n, 4'b0100, 1'b0);
    req_b = 4'b1000;
    step();
    chk_dut("nb gap", gnt_n, val_n, id_n, pre_n, 4'b0000, 1'b0);
    step();
    chk_dut("nb next", gnt_n, val_n, id_n, pre_n, 4'b1000, 1'b0);
    req_b = 4'b0000;
    step();
    chk_dut("nb idle", gnt_n, val_n, id_n, pre_n, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
